// File: rtl/aes_round_engine_if.sv
// aes_round_engine_if: plaintext-in / ciphertext-out handshake bundle for the
// iterative AES-128 round engine. master = block source/sink side, slave = engine.
interface aes_round_engine_if #(
   parameter int NR = 10
);
   logic                    in_valid;
   logic                    in_ready;
   logic [127:0]            plaintext;
   logic [(NR+1)*128-1:0]   round_keys;
   logic                    out_valid;
   logic                    out_ready;
   logic [127:0]            ciphertext;
   logic                    busy;

   modport master (
      output in_valid, plaintext, round_keys, out_ready,
      input  in_ready, out_valid, ciphertext, busy
   );

   modport slave (
      input  in_valid, plaintext, round_keys, out_ready,
      output in_ready, out_valid, ciphertext, busy
   );
endinterface

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryption datapath, one round per clock.
// Accepts a plaintext block, runs NR rounds against round_keys and holds the
// ciphertext on a valid/ready port until it is taken.
// Build macro AES_ROUND_KEY_LATCH_EN: when defined, round_keys is captured on
// the accept cycle and all rounds use that copy; otherwise keys are used live.
module aes_round_engine #(
   parameter int NR = 10
) (
   input logic               clk,
   input logic               rst_n,
   aes_round_engine_if.slave bus
);
   localparam int         KEY_W      = (NR + 1) * 128;
   localparam logic [3:0] LAST_ROUND = 4'(NR);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       state;
   logic [3:0]   round;
   logic [127:0] st;
   logic [127:0] ct;
   logic         in_ready_r;
   logic         out_valid_r;
   logic         busy_r;

   logic [127:0] sub_out;
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [127:0] round_key;
   logic         accept;
   logic [KEY_W-1:0] key_src;
   logic [127:0] key_arr [0:NR];

   // GF(2^8) multiply by x, reduction polynomial 0x11B
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product, shift-and-xor
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse (a^254, 0 maps to 0) followed by the affine map
   function automatic logic [7:0] sbox_byte(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // One state column through four S-boxes
   function automatic logic [31:0] sbox_4byte(input logic [31:0] w);
      return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
              sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
   endfunction

   // Row r rotates left by r columns; byte (row r, col c) sits at index 4c+r
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   // Per-column multiply by the circulant {02,03,01,01}
   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   assign accept = (state == IDLE) && bus.in_valid && in_ready_r;

`ifdef AES_ROUND_KEY_LATCH_EN
   logic [KEY_W-1:0] key_reg;

   // Snapshot the full key schedule when a block is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_reg <= '0;
      end else if (accept) begin
         key_reg <= bus.round_keys;
      end
   end

   assign key_src = key_reg;
`else
   assign key_src = bus.round_keys;
`endif

   for (genvar k = 0; k <= NR; k++) begin : g_key_slice
      assign key_arr[k] = key_src[128*k +: 128];
   end

   // Whole-state SubBytes in one cycle, one 4-byte S-box block per column
   for (genvar c = 0; c < 4; c++) begin : g_sbox_4byte
      assign sub_out[127-32*c -: 32] = sbox_4byte(st[127-32*c -: 32]);
   end

   assign shifted   = shift_rows(sub_out);
   assign mixed     = mix_columns(shifted);
   assign round_key = key_arr[round];

   // Control FSM and round state: accept, iterate rounds, hold result until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         round       <= 4'd0;
         st          <= '0;
         ct          <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               round      <= 4'd0;
               in_ready_r <= 1'b1;
               if (accept) begin
                  // key0 whitening always uses the live key: it is the one being captured
                  st         <= bus.plaintext ^ bus.round_keys[127:0];
                  round      <= 4'd1;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= ROUND;
               end
            end
            ROUND: begin
               if (round == LAST_ROUND) begin
                  // final round drops MixColumns; result is published and held
                  st          <= shifted ^ round_key;
                  ct          <= shifted ^ round_key;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  st    <= mixed ^ round_key;
                  round <= round + 4'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
                  round       <= 4'd0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.ciphertext = ct;
   assign bus.busy       = busy_r;
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed FIPS-197 vectors plus a byte-level AES model
// that is compared against the engine outputs on every clock.
// Honours AES_ROUND_KEY_LATCH_EN the same way the design does.
module tb_aes_round_engine;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   aes_round_engine_if #(.NR(10)) bus ();

   aes_round_engine #(.NR(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] sbox_t [256];

   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_ne(input string name, input logic [127:0] act, input logic [127:0] bad);
      checks++;
      if (act === bad) begin
         failures++;
         $display("FAIL %s actual=%h required=anything_but_%h", name, act, bad);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   // S-box table via the generator-3 walk: p steps by *3, q tracks 1/p
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [1407:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] rk;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int k = 0; k <= 10; k++) rk[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      return rk;
   endfunction

   function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1407:0] rk);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
               for (int j = 0; j < 4; j++)
                  s[4*c+j] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03) ^ a[(j+2)%4] ^ a[(j+3)%4];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[128*r + 127 - 8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // Transaction-level model of the engine
   logic          m_busy = 1'b0;
   logic          m_in_ready = 1'b0;
   logic          m_out_valid = 1'b0;
   int            m_cnt = 0;
   logic [127:0]  m_pt = '0;
   logic [127:0]  m_ct = '0;
   logic [1407:0] m_keys = '0;

   always @(posedge clk or negedge rst_n) begin : model
      int            n;
      logic [1407:0] k;
      if (!rst_n) begin
         m_busy      <= 1'b0;
         m_in_ready  <= 1'b0;
         m_out_valid <= 1'b0;
         m_cnt       <= 0;
         m_ct        <= '0;
      end else if (!m_busy) begin
         if (bus.in_valid && m_in_ready) begin
            m_busy     <= 1'b1;
            m_in_ready <= 1'b0;
            m_cnt      <= 0;
            m_pt       <= bus.plaintext;
            m_keys     <= bus.round_keys;
         end else begin
            m_in_ready <= 1'b1;
         end
      end else if (!m_out_valid) begin
         n = m_cnt + 1;
         k = m_keys;
`ifndef AES_ROUND_KEY_LATCH_EN
         k[128*n +: 128] = bus.round_keys[128*n +: 128];
`endif
         m_cnt  <= n;
         m_keys <= k;
         if (n == 10) begin
            m_ct        <= model_encrypt(m_pt, k);
            m_out_valid <= 1'b1;
         end
      end else if (bus.out_ready) begin
         m_out_valid <= 1'b0;
         m_busy      <= 1'b0;
         m_in_ready  <= 1'b1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk1("in_ready", bus.in_ready, m_in_ready);
      chk1("out_valid", bus.out_valid, m_out_valid);
      chk1("busy", bus.busy, m_busy);
      if (m_out_valid) chk128("ciphertext", bus.ciphertext, m_ct);
   end

   task automatic send(input logic [127:0] pt, input logic [1407:0] rk, input bit keep, output int acc);
      logic rdy;
      bus.plaintext  = pt;
      bus.round_keys = rk;
      bus.in_valid   = 1'b1;
      acc = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) begin
            #1;
            acc = cyc;
            break;
         end
      end
      if (acc < 0) chk1("accept_timeout", 1'b0, 1'b1);
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int seen);
      seen = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = cyc;
            break;
         end
      end
      if (seen < 0) chk1("out_valid_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1407:0] rk_b, rk_c;
      logic [127:0]  pts [3];
      int            acc, seen;
      int            sacc [3];

      build_sbox();
      rk_b = expand(KEY_B);
      rk_c = expand(KEY_C);
      chk128("model_sbox_00", {120'h0, sbox_t[8'h00]}, 128'h63);
      chk128("model_sbox_53", {120'h0, sbox_t[8'h53]}, 128'hed);
      chk128("model_rk10_b", rk_b[1407:1280], RK10_B);
      chk128("model_ct_b", model_encrypt(PT_B, rk_b), CT_B);
      chk128("model_ct_c", model_encrypt(PT_C, rk_c), CT_C);

      bus.in_valid   = 1'b0;
      bus.plaintext  = '0;
      bus.round_keys = '0;
      bus.out_ready  = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("reset_in_ready", bus.in_ready, 1'b0);
      chk1("reset_out_valid", bus.out_valid, 1'b0);
      chk1("reset_busy", bus.busy, 1'b0);
      chk128("reset_ciphertext", bus.ciphertext, 128'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk1("post_reset_in_ready", bus.in_ready, 1'b1);

      // FIPS-197 App. B with latency
      send(PT_B, rk_b, 1'b0, acc);
      wait_out(seen);
      chk_int("latency_b", seen - acc, 10);
      chk128("ct_app_b", bus.ciphertext, CT_B);
      chk1("done_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk1("after_done_out_valid", bus.out_valid, 1'b0);

      // FIPS-197 App. C.1
      send(PT_C, rk_c, 1'b0, acc);
      wait_out(seen);
      chk128("ct_app_c", bus.ciphertext, CT_C);

      // Backpressure: hold the result for 20 cycles
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      send(PT_B, rk_b, 1'b0, acc);
      wait_out(seen);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk1("bp_out_valid", bus.out_valid, 1'b1);
         chk1("bp_in_ready", bus.in_ready, 1'b0);
         chk128("bp_ciphertext", bus.ciphertext, CT_B);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk1("bp_release_out_valid", bus.out_valid, 1'b0);
      chk1("bp_release_in_ready", bus.in_ready, 1'b1);
      chk1("bp_release_busy", bus.busy, 1'b0);

      // Streaming: in_valid and out_ready held high for three blocks
      pts[0] = PT_B;
      pts[1] = PT_C;
      pts[2] = 128'h0123456789abcdeffedcba9876543210;
      for (int i = 0; i < 3; i++) send(pts[i], rk_c, 1'b1, sacc[i]);
      bus.in_valid = 1'b0;
      chk_int("stream_spacing_01", sacc[1] - sacc[0], 12);
      chk_int("stream_spacing_12", sacc[2] - sacc[1], 12);
      wait_out(seen);
      @(posedge clk);

      // Reset during round 5: block discarded, next block correct
      send(PT_B, rk_b, 1'b0, acc);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk1("midreset_out_valid", bus.out_valid, 1'b0);
      chk1("midreset_busy", bus.busy, 1'b0);
      chk1("midreset_in_ready", bus.in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(PT_C, rk_c, 1'b0, acc);
      wait_out(seen);
      chk_int("latency_after_reset", seen - acc, 10);
      chk128("ct_after_reset", bus.ciphertext, CT_C);
      @(posedge clk);

      // Round keys cleared right after accept
      send(PT_B, rk_b, 1'b0, acc);
      bus.round_keys = '0;
      wait_out(seen);
`ifdef AES_ROUND_KEY_LATCH_EN
      chk128("keychange_latched", bus.ciphertext, CT_B);
`else
      chk_ne("keychange_live", bus.ciphertext, CT_B);
`endif
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
